// File: rtl/clock_pkg.sv
// Shared constants for the sample-rate clock generator.
// Base prescale factor and counter widths.
package clock_pkg;
  localparam int PRESCALE_DEF = 4;
  localparam int CNT_W        = 2;
  localparam int RATIO_W      = 3;
endpackage

// File: rtl/clock_prescaler.sv
// Modulo-PRESCALE base-tick counter.
// Holds while run is low; tick flags the last count.
module clock_prescaler
  import clock_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int W        = CNT_W
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  logic [W-1:0] counter_q;
  logic [W-1:0] counter_d;

  // Advance while running; power-of-two size wraps naturally.
  always_comb begin
    counter_d = counter_q;
    if (run) counter_d = counter_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) counter_q <= '0;
    else        counter_q <= counter_d;
  end

  assign tick = (counter_q == W'(PRESCALE - 1));

endmodule

// File: rtl/clock.sv
// Sample-rate clock: base-rate square wave, stretched
// by ratio+1 in slow interpolated playback, frozen on pause.
module clock
  import clock_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               isNormalSpeed,
  input  logic               interp,
  input  logic               pause,
  input  logic               isRecord,
  output logic               clkOut
);

  logic               run;
  logic               slow;
  logic               tick;
  logic [RATIO_W-1:0] counter2_q;
  logic [RATIO_W-1:0] counter2_d;
  logic               slow_clock_q;
  logic               slow_clock_d;

  assign run  = isRecord | ~pause;
  assign slow = ~isRecord & ~isNormalSpeed & interp;

  clock_prescaler #(
    .PRESCALE (PRESCALE),
    .W        ($clog2(PRESCALE))
  ) u_pre (
    .clk50 (clk50),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  // On each tick toggle, or count up toward ratio in slow mode.
  // The >= compare lets a lowered ratio wrap on the next tick.
  always_comb begin
    counter2_d   = counter2_q;
    slow_clock_d = slow_clock_q;
    if (run && tick) begin
      if (!slow || (counter2_q >= ratio)) begin
        slow_clock_d = ~slow_clock_q;
        counter2_d   = '0;
      end else begin
        counter2_d = counter2_q + 1'b1;
      end
    end
  end

  // Stretch counter and output toggle flop.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      counter2_q   <= '0;
      slow_clock_q <= 1'b0;
    end else begin
      counter2_q   <= counter2_d;
      slow_clock_q <= slow_clock_d;
    end
  end

  assign clkOut = slow_clock_q;

endmodule

// File: tb/tb_clock.sv
// Directed bench for the sample-rate clock generator.
// Edges are counted from the first rising edge after reset release.
module tb_clock;
  import clock_pkg::*;

  logic               clk50 = 1'b0;
  logic               rst_n = 1'b0;
  logic [RATIO_W-1:0] ratio = '0;
  logic               isNormalSpeed = 1'b0;
  logic               interp = 1'b0;
  logic               pause = 1'b0;
  logic               isRecord = 1'b0;
  logic               clkOut;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  clock dut (
    .clk50         (clk50),
    .rst_n         (rst_n),
    .ratio         (ratio),
    .isNormalSpeed (isNormalSpeed),
    .interp        (interp),
    .pause         (pause),
    .isRecord      (isRecord),
    .clkOut        (clkOut)
  );

  always #5 clk50 = ~clk50;

  task automatic check(input string tag, input logic got,
                       input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // Advance to just after rising edge k.
  task automatic goto(input int k);
    while (edge_n < k) begin
      @(posedge clk50);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk50);
    #1;
    check("rst_low", clkOut, 1'b0);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic set_mode(input logic rec, input logic ns,
                          input logic ip, input logic [2:0] r);
    isRecord      = rec;
    isNormalSpeed = ns;
    interp        = ip;
    ratio         = r;
    pause         = 1'b0;
  endtask

  initial begin
    // record, base rate, pause ignored
    set_mode(1'b1, 1'b0, 1'b0, 3'd0);
    do_reset();
    goto(3);  check("rec_e3", clkOut, 1'b0);
    goto(4);  check("rec_e4", clkOut, 1'b1);
    goto(7);  check("rec_e7", clkOut, 1'b1);
    goto(8);  check("rec_e8", clkOut, 1'b0);
    goto(12); check("rec_e12", clkOut, 1'b1);
    pause = 1'b1;
    goto(16); check("rec_pz16", clkOut, 1'b0);
    goto(20); check("rec_pz20", clkOut, 1'b1);

    // slow, ratio 7
    set_mode(1'b0, 1'b0, 1'b1, 3'd7);
    do_reset();
    goto(31); check("r7_e31", clkOut, 1'b0);
    goto(32); check("r7_e32", clkOut, 1'b1);
    goto(63); check("r7_e63", clkOut, 1'b1);
    goto(64); check("r7_e64", clkOut, 1'b0);
    goto(95); check("r7_e95", clkOut, 1'b0);
    goto(96); check("r7_e96", clkOut, 1'b1);

    // slow, ratio 0 acts as base rate
    set_mode(1'b0, 1'b0, 1'b1, 3'd0);
    do_reset();
    goto(3);  check("r0_e3", clkOut, 1'b0);
    goto(4);  check("r0_e4", clkOut, 1'b1);
    goto(8);  check("r0_e8", clkOut, 1'b0);
    goto(12); check("r0_e12", clkOut, 1'b1);

    // slow without interp stays at base rate
    set_mode(1'b0, 1'b0, 1'b0, 3'd7);
    do_reset();
    goto(4);  check("ni_e4", clkOut, 1'b1);
    goto(8);  check("ni_e8", clkOut, 1'b0);
    goto(12); check("ni_e12", clkOut, 1'b1);

    // pause for 20 edges during the high phase
    set_mode(1'b0, 1'b0, 1'b1, 3'd7);
    do_reset();
    goto(32); check("pz_e32", clkOut, 1'b1);
    goto(40);
    pause = 1'b1;
    goto(60); check("pz_hold", clkOut, 1'b1);
    pause = 1'b0;
    goto(64); check("pz_e64", clkOut, 1'b1);
    goto(83); check("pz_e83", clkOut, 1'b1);
    goto(84); check("pz_e84", clkOut, 1'b0);

    // lower ratio mid-count
    set_mode(1'b0, 1'b0, 1'b1, 3'd7);
    do_reset();
    goto(48); check("dr_e48", clkOut, 1'b1);
    ratio = 3'd1;
    goto(51); check("dr_e51", clkOut, 1'b1);
    goto(52); check("dr_e52", clkOut, 1'b0);
    goto(59); check("dr_e59", clkOut, 1'b0);
    goto(60); check("dr_e60", clkOut, 1'b1);
    goto(67); check("dr_e67", clkOut, 1'b1);
    goto(68); check("dr_e68", clkOut, 1'b0);

    // async reset during high phase
    set_mode(1'b0, 1'b1, 1'b0, 3'd0);
    do_reset();
    goto(4);  check("ar_e4", clkOut, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async", clkOut, 1'b0);
    do_reset();
    goto(3);  check("ar_re3", clkOut, 1'b0);
    goto(4);  check("ar_re4", clkOut, 1'b1);
    goto(8);  check("ar_re8", clkOut, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
